// File: rtl/loader_pkg.sv
// loader_pkg: shared constants and state encoding for the boot-time program loader.
//   HDR_BYTES / BYTES_PER_WORD / BYTE_W / WORD_W: stream framing constants.
//   state_e: loader FSM states (fixed 3-bit encoding).
package loader_pkg;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_W         = 8;
  localparam int WORD_W         = BYTES_PER_WORD * BYTE_W;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LEN0  = 3'd1;
  localparam logic [2:0] ST_LEN1  = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_WRITE = 3'd4;
  localparam logic [2:0] ST_CSUM  = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;
  localparam logic [2:0] ST_ERR   = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_LEN0  = ST_LEN0,
    S_LEN1  = ST_LEN1,
    S_DATA  = ST_DATA,
    S_WRITE = ST_WRITE,
    S_CSUM  = ST_CSUM,
    S_DONE  = ST_DONE,
    S_ERR   = ST_ERR
  } state_e;

endpackage

// File: rtl/loader_word_pack.sv
// loader_word_pack: packs accepted bytes LSB-first into a 32-bit word.
//   clk_i, rst_ni  : clock, async active-low reset
//   byte_i         : incoming byte
//   accept_i       : byte is consumed this cycle
//   clear_i        : drop any partial word and restart at byte 0
//   word_o         : packing register (complete once the 4th byte lands)
//   word_full_o    : the byte being accepted now is the last of its word
module loader_word_pack
  import loader_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [BYTE_W-1:0] byte_i,
  input  logic              accept_i,
  input  logic              clear_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_full_o
);

  logic [1:0]        idx_q;
  logic [WORD_W-1:0] word_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q  <= '0;
      word_q <= '0;
    end else if (clear_i) begin
      idx_q  <= '0;
      word_q <= '0;
    end else if (accept_i) begin
      word_q[BYTE_W*int'(idx_q) +: BYTE_W] <= byte_i;
      idx_q <= idx_q + 2'd1;  // wraps to 0 after the last byte of a word
    end
  end

  assign word_o      = word_q;
  assign word_full_o = accept_i && (idx_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/prog_loader.sv
// prog_loader: boot-time loader feeding the CPU instruction memory.
//   Parses a little-endian 16-bit word-count header from a valid/ready byte
//   stream, packs data bytes into 32-bit words, writes them to the IM port and
//   holds the CPU in reset until the image is complete.
// Ports:
//   Clk, Reset         : clock, async active-low reset
//   start              : pulse; begins/restarts a load (ignored while busy)
//   rx_valid/rx_data   : byte stream in; rx_ready: loader accepts a byte
//   im_we/im_addr/im_wdata : IM write port, one strobe per word
//   cpu_rst_n          : CPU reset, released only in DONE
//   busy/done/err      : load status; word_cnt: words written so far
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing XOR
// checksum byte over all header and data bytes before DONE.
module prog_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_cnt
);

  localparam logic [31:0] CAP = 32'd1 << ADDR_W;

`ifdef LOADER_CHECKSUM_EN
  localparam state_e S_FIN = S_CSUM;
`else
  localparam state_e S_FIN = S_DONE;
`endif

  state_e          state_q, state_d;
  logic [7:0]      len0_q;
  logic [15:0]     len_q;
  logic [15:0]     hdr_n;
  logic [ADDR_W:0] word_cnt_q;
  logic [31:0]     tmo_q;
  logic            accept, tmo_active, tmo_hit, restart;
  logic            pk_full;
  logic [31:0]     pk_word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]      csum_q;
`endif

  assign accept     = rx_valid && rx_ready;
  assign hdr_n      = {rx_data, len0_q};
  assign restart    = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
  assign tmo_active = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                      (state_q == S_DATA) || (state_q == S_CSUM);
  // Fires on the idle cycle that would bring the counter to TIMEOUT_CYC.
  assign tmo_hit    = (TIMEOUT_CYC != 0) && tmo_active && !accept &&
                      (tmo_q == 32'(TIMEOUT_CYC - 1));

  loader_word_pack u_pack (
    .clk_i       (Clk),
    .rst_ni      (Reset),
    .byte_i      (rx_data),
    .accept_i    (accept && state_q == S_DATA),
    .clear_i     (restart),
    .word_o      (pk_word),
    .word_full_o (pk_full)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LEN0;
      S_LEN0: begin
        if (accept)       state_d = S_LEN1;
        else if (tmo_hit) state_d = S_ERR;
      end
      S_LEN1: begin
        if (accept) begin
          if (hdr_n == 16'd0)          state_d = S_FIN;
          else if (32'(hdr_n) > CAP)   state_d = S_ERR;
          else                         state_d = S_DATA;
        end else if (tmo_hit) begin
          state_d = S_ERR;
        end
      end
      S_DATA: begin
        if (pk_full)      state_d = S_WRITE;
        else if (tmo_hit) state_d = S_ERR;
      end
      S_WRITE: state_d = (32'(word_cnt_q) + 32'd1 == 32'(len_q)) ? S_FIN : S_DATA;
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (accept)       state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
        else if (tmo_hit) state_d = S_ERR;
      end
`endif
      S_DONE, S_ERR: if (start) state_d = S_LEN0;
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs are registered as a decode of the next state.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= S_IDLE;
      rx_ready   <= 1'b0;
      im_we      <= 1'b0;
      cpu_rst_n  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      len0_q     <= '0;
      len_q      <= '0;
      word_cnt_q <= '0;
      tmo_q      <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      rx_ready  <= (state_d == S_LEN0) || (state_d == S_LEN1) ||
                   (state_d == S_DATA) || (state_d == S_CSUM);
      im_we     <= (state_d == S_WRITE);
      busy      <= (state_d == S_LEN0) || (state_d == S_LEN1) || (state_d == S_DATA) ||
                   (state_d == S_WRITE) || (state_d == S_CSUM);
      done      <= (state_d == S_DONE);
      err       <= (state_d == S_ERR);
      cpu_rst_n <= (state_d == S_DONE);

      if (accept || state_d != state_q || !tmo_active) tmo_q <= '0;
      else                                              tmo_q <= tmo_q + 32'd1;

      if (accept && state_q == S_LEN0) len0_q <= rx_data;
      if (accept && state_q == S_LEN1) len_q  <= hdr_n;

      if (restart)                  word_cnt_q <= '0;
      else if (state_q == S_WRITE)  word_cnt_q <= word_cnt_q + 1'b1;

`ifdef LOADER_CHECKSUM_EN
      if (restart)                            csum_q <= '0;
      else if (accept && state_q != S_CSUM)   csum_q <= csum_q ^ rx_data;
`endif
    end
  end

  assign im_addr  = word_cnt_q[ADDR_W-1:0];
  assign im_wdata = pk_word;
  assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

  localparam int AW  = 2;
  localparam int TMO = 16;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          start = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_ready, im_we, cpu_rst_n, busy, done, err;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;
  logic [AW:0]   word_cnt;

  int tests = 0;
  int fails = 0;
  int nwr   = 0;
  logic [31:0] mem [0:3];

  prog_loader #(.ADDR_W(AW), .TIMEOUT_CYC(TMO)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .err(err), .word_cnt(word_cnt)
  );

  always #5 Clk = ~Clk;

  // IM model: capture writes mid-cycle
  always @(negedge Clk) begin
    if (im_we) begin
      mem[im_addr] <= im_wdata;
      nwr <= nwr + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    while (!rx_ready && n < 40) begin
      @(negedge Clk);
      n++;
    end
    if (!rx_ready) chk("rx_ready_wait", {31'b0, rx_ready}, 32'd1);
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #1 Reset = 1'b0;
    #2;
    chk("rst_rx_ready", {31'b0, rx_ready}, 0);
    chk("rst_cpu_rst_n", {31'b0, cpu_rst_n}, 0);
    chk("rst_status", {29'b0, busy, done, err}, 0);
    chk("rst_word_cnt", 32'(word_cnt), 0);
    @(negedge Clk) Reset = 1'b1;
    tick();
    chk("idle_rx_ready", {31'b0, rx_ready}, 0);

    // 1: two-word image
    pulse_start();
    chk("t1_busy", {31'b0, busy}, 1);
    chk("t1_rx_ready", {31'b0, rx_ready}, 1);
    send(8'h02); send(8'h00);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    chk("t1_we0", {31'b0, im_we}, 1);
    chk("t1_addr0", 32'(im_addr), 0);
    chk("t1_wdata0", im_wdata, 32'h44332211);
    chk("t1_rx_ready_write", {31'b0, rx_ready}, 0);
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    chk("t1_we1", {31'b0, im_we}, 1);
    chk("t1_addr1", 32'(im_addr), 1);
    chk("t1_done_early", {31'b0, done}, 0);
    tick();
`ifdef LOADER_CHECKSUM_EN
    chk("t1_csum_wait", {31'b0, done}, 0);
    send(8'h46);
`endif
    chk("t1_done", {31'b0, done}, 1);
    chk("t1_cpu_rst_n", {31'b0, cpu_rst_n}, 1);
    chk("t1_word_cnt", 32'(word_cnt), 2);
    chk("t1_busy_off", {31'b0, busy}, 0);
    chk("t1_nwr", 32'(nwr), 2);
    chk("t1_mem0", mem[0], 32'h44332211);
    chk("t1_mem1", mem[1], 32'hDDCCBBAA);
    // stray bytes in DONE are not accepted
    rx_valid = 1'b1; rx_data = 8'h99;
    tick(); tick(); tick();
    chk("done_stray_ready", {31'b0, rx_ready}, 0);
    chk("done_stray_cnt", 32'(word_cnt), 2);
    rx_valid = 1'b0;

    // 2: empty image, reload from DONE
    pulse_start();
    chk("t2_done_drop", {31'b0, done}, 0);
    chk("t2_cpu_rst", {31'b0, cpu_rst_n}, 0);
    chk("t2_cnt_clr", 32'(word_cnt), 0);
    send(8'h00); send(8'h00);
`ifdef LOADER_CHECKSUM_EN
    chk("t2_csum_wait", {31'b0, done}, 0);
    send(8'h00);
`endif
    chk("t2_done", {31'b0, done}, 1);
    chk("t2_nwr", 32'(nwr), 2);

    // 3: header exceeds capacity (5 > 4)
    pulse_start();
    send(8'h05); send(8'h00);
    chk("t3_err", {31'b0, err}, 1);
    chk("t3_busy", {31'b0, busy}, 0);
    tick(); tick();
    chk("t3_cpu_rst", {31'b0, cpu_rst_n}, 0);
    chk("t3_rx_ready", {31'b0, rx_ready}, 0);
    chk("t3_nwr", 32'(nwr), 2);

    // boundary: N == capacity, start while busy is ignored
    pulse_start();
    chk("tb_err_drop", {31'b0, err}, 0);
    send(8'h04); send(8'h00);
    pulse_start();
    chk("tb_busy_start", {31'b0, busy}, 1);
    for (int i = 1; i <= 16; i++) send(8'(i));
    tick();
`ifdef LOADER_CHECKSUM_EN
    send(8'h14);
`endif
    chk("tb_done", {31'b0, done}, 1);
    chk("tb_word_cnt", 32'(word_cnt), 4);
    chk("tb_nwr", 32'(nwr), 6);
    chk("tb_mem0", mem[0], 32'h04030201);
    chk("tb_mem3", mem[3], 32'h100F0E0D);

    // 4: timeout mid-DATA, then successful reload
    pulse_start();
    send(8'h02); send(8'h00); send(8'h11); send(8'h22);
    repeat (15) tick();
    chk("t4_err_early", {31'b0, err}, 0);
    chk("t4_busy", {31'b0, busy}, 1);
    tick();
    chk("t4_err", {31'b0, err}, 1);
    chk("t4_cpu_rst", {31'b0, cpu_rst_n}, 0);
    pulse_start();
    send(8'h01); send(8'h00); send(8'h5A); send(8'hA5); send(8'hC3); send(8'h3C);
    tick();
`ifdef LOADER_CHECKSUM_EN
    send(8'h01);
`endif
    chk("t4_done", {31'b0, done}, 1);
    chk("t4_mem0", mem[0], 32'h3CC3A55A);
    chk("t4_word_cnt", 32'(word_cnt), 1);

    // 5: async reset mid-DATA
    pulse_start();
    send(8'h02); send(8'h00); send(8'h11); send(8'h22);
    rx_valid = 1'b1; rx_data = 8'h33;
    #3 Reset = 1'b0;
    #1;
    chk("t5_rx_ready", {31'b0, rx_ready}, 0);
    chk("t5_busy", {31'b0, busy}, 0);
    chk("t5_wdata", im_wdata, 0);
    chk("t5_word_cnt", 32'(word_cnt), 0);
    @(negedge Clk) Reset = 1'b1;
    tick(); tick(); tick();
    chk("t5_idle_ready", {31'b0, rx_ready}, 0);
    chk("t5_idle_status", {29'b0, busy, done, err}, 0);
    rx_valid = 1'b0;
    pulse_start();
    send(8'h01); send(8'h00); send(8'h77); send(8'h66); send(8'h55); send(8'h44);
    tick();
`ifdef LOADER_CHECKSUM_EN
    send(8'h01);
`endif
    chk("t5_done", {31'b0, done}, 1);
    chk("t5_mem0", mem[0], 32'h44556677);

`ifdef LOADER_CHECKSUM_EN
    // 6: checksum match and mismatch
    pulse_start();
    send(8'h01); send(8'h00); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    tick();
    send(8'h05);
    chk("t6_done", {31'b0, done}, 1);
    chk("t6_mem0", mem[0], 32'h04030201);
    pulse_start();
    send(8'h01); send(8'h00); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    tick();
    send(8'h06);
    chk("t6_err", {31'b0, err}, 1);
    chk("t6_cpu_rst", {31'b0, cpu_rst_n}, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
